// File: rtl/score_bcd_sequencer.sv
// Converts an unsigned binary score into nine BCD digits by double-dabble and
// publishes the result to the display only on a start-of-frame pulse.
module score_bcd_sequencer #(
    parameter int VALUE_W    = 30,
    parameter int LEAD_BLANK = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               valueValid,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic [3:0]         digit1,
    output logic [3:0]         digit2,
    output logic [3:0]         digit3,
    output logic [3:0]         digit4,
    output logic [3:0]         digit5,
    output logic [3:0]         digit6,
    output logic [3:0]         digit7,
    output logic [3:0]         digit8,
    output logic [3:0]         digit9,
    output logic [8:0]         digitEnN,
    output logic               overflow
);
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int CMP_W = (VALUE_W > 30) ? VALUE_W : 30;
    localparam logic [CMP_W-1:0] MAX_SCORE = CMP_W'(999999999);
    localparam logic [8:0] EN_RESET = (LEAD_BLANK != 0) ? 9'h001 : 9'h1FF;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, PUBLISH} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [VALUE_W-1:0] r_bin;
    logic [VALUE_W-1:0] r_pendVal;
    logic               r_pendValid;
    logic               r_ovfPend;
    logic               r_overflow;
    logic [35:0]        r_bcd;
    logic [35:0]        r_digits;
    logic [CNT_W-1:0]   r_cnt;
    logic [8:0]         r_digitEnN;
    logic [35:0]        w_bcdAdj;
    logic [8:0]         w_enN;
    logic               w_reqAny;
    logic [VALUE_W-1:0] w_reqVal;

    // A request arriving in the PUBLISH cycle is newer than any stored one.
    assign w_reqAny = valueValid | r_pendValid;
    assign w_reqVal = valueValid ? value : r_pendVal;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valueValid) w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_next = HOLD;
            HOLD:    if (startOfFrame) w_next = PUBLISH;
            PUBLISH: w_next = w_reqAny ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE) || r_pendValid;
    end

    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < 9; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // A digit stays lit when any more-significant digit is non-zero.
    always_comb begin
        w_enN = 9'h1FF;
        if (LEAD_BLANK != 0) begin
            for (int i = 1; i < 9; i++) w_enN[i] = |(r_bcd >> (4*i));
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bin       <= '0;
            r_pendVal   <= '0;
            r_pendValid <= 1'b0;
            r_ovfPend   <= 1'b0;
            r_overflow  <= 1'b0;
            r_bcd       <= '0;
            r_digits    <= '0;
            r_cnt       <= '0;
            r_digitEnN  <= EN_RESET;
        end else begin
            if (r_state != IDLE && valueValid) begin
                r_pendVal   <= value;
                r_pendValid <= 1'b1;
            end
            case (r_state)
                IDLE: if (valueValid) r_bin <= value;
                LOAD: begin
                    if (CMP_W'(r_bin) > MAX_SCORE) begin
                        r_bin     <= VALUE_W'(MAX_SCORE);
                        r_ovfPend <= 1'b1;
                    end else begin
                        r_ovfPend <= 1'b0;
                    end
                    r_bcd <= '0;
                    r_cnt <= CNT_W'(VALUE_W);
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcdAdj, r_bin} << 1;
                    r_cnt          <= r_cnt - CNT_W'(1);
                end
                PUBLISH: begin
                    r_digits   <= r_bcd;
                    r_digitEnN <= w_enN;
                    r_overflow <= r_ovfPend;
                    if (w_reqAny) begin
                        r_bin       <= w_reqVal;
                        r_pendValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digit1   = r_digits[3:0];
    assign digit2   = r_digits[7:4];
    assign digit3   = r_digits[11:8];
    assign digit4   = r_digits[15:12];
    assign digit5   = r_digits[19:16];
    assign digit6   = r_digits[23:20];
    assign digit7   = r_digits[27:24];
    assign digit8   = r_digits[31:28];
    assign digit9   = r_digits[35:32];
    assign digitEnN = r_digitEnN;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_score_bcd_sequencer.sv
// Bench for score_bcd_sequencer: directed scenarios plus random scores checked
// against a decimal model built from division and remainder.
module tb_score_bcd_sequencer;
    localparam int VW = 30;
    localparam int LB = 1;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          valueValid;
    logic [VW-1:0] value;
    logic          busy;
    logic          overflow;
    logic [3:0]    d1, d2, d3, d4, d5, d6, d7, d8, d9;
    logic [8:0]    digitEnN;
    logic [35:0]   obs_digits;
    logic [35:0]   shown_exp;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    score_bcd_sequencer #(.VALUE_W(VW), .LEAD_BLANK(LB)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .valueValid(valueValid), .value(value), .busy(busy),
        .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4), .digit5(d5),
        .digit6(d6), .digit7(d7), .digit8(d8), .digit9(d9),
        .digitEnN(digitEnN), .overflow(overflow)
    );

    assign obs_digits = {d9, d8, d7, d6, d5, d4, d3, d2, d1};

    function automatic longint unsigned clamp(input longint unsigned v);
        return (v > 64'd999999999) ? 64'd999999999 : v;
    endfunction

    function automatic logic [35:0] model_bcd(input longint unsigned v);
        longint unsigned c = clamp(v);
        logic [35:0] r = '0;
        for (int k = 0; k < 9; k++) begin
            r[4*k +: 4] = 4'(c % 10);
            c = c / 10;
        end
        return r;
    endfunction

    function automatic logic [8:0] model_en(input longint unsigned v);
        longint unsigned c = clamp(v);
        int nd = 0;
        if (LB == 0) return 9'h1FF;
        do begin
            nd++;
            c = c / 10;
        end while (c != 0);
        return 9'((1 << nd) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input longint unsigned v);
        valueValid = 1'b1;
        value      = VW'(v);
        tick();
        valueValid = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_digits"}, obs_digits, 36'h0);
        chk({tag, "_en"}, digitEnN, (LB != 0) ? 9'h001 : 9'h1FF);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Waits, pulses startOfFrame, and checks the publish edge timing and result.
    task automatic publish_check(input string tag, input longint unsigned v,
                                 input int wait_cycles, input logic busy_after);
        logic all_busy = 1'b1;
        for (int i = 0; i < wait_cycles; i++) begin
            all_busy &= busy;
            tick();
        end
        chk({tag, "_busy_interval"}, all_busy, 1'b1);
        frame();
        chk({tag, "_held"}, obs_digits, shown_exp);
        tick();
        shown_exp = model_bcd(v);
        chk({tag, "_digits"}, obs_digits, shown_exp);
        chk({tag, "_en"}, digitEnN, model_en(v));
        chk({tag, "_ovf"}, overflow, (v > 64'd999999999));
        chk({tag, "_busy_after"}, busy, busy_after);
    endtask

    task automatic convert(input string tag, input longint unsigned v, input int wait_cycles);
        request(v);
        chk({tag, "_busy_accept"}, busy, 1'b1);
        publish_check(tag, v, wait_cycles, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned rv;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        valueValid   = 1'b0;
        value        = '0;
        shown_exp    = '0;
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        tick();

        convert("v1234", 1234, 49);
        convert("v0", 0, 31);
        convert("v999999999", 999999999, 31);
        convert("vmax30", 64'h3FFFFFFF, 31);
        convert("v7", 7, 31);

        frame();
        tick();
        chk("sof_idle_ignored", obs_digits, shown_exp);

        request(55);
        tick();
        request(66);
        request(77);
        publish_check("q55", 55, 38, 1'b1);
        publish_check("q77", 77, 40, 1'b0);

        request(321);
        repeat (4) tick();
        frame();
        repeat (5) tick();
        chk("sof_shift_ignored", obs_digits, shown_exp);
        chk("sof_shift_busy", busy, 1'b1);
        publish_check("s321", 321, 25, 1'b0);

        request(500);
        repeat (10) tick();
        #2;
        resetN = 1'b0;
        #1;
        shown_exp = '0;
        check_reset_state("midrst");
        tick();
        resetN = 1'b1;
        tick();
        chk("midrst_busy_release", busy, 1'b0);
        frame();
        tick();
        tick();
        chk("midrst_no_publish", obs_digits, 36'h0);
        convert("after_rst", 42, 31);

        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 2))
                0:       rv = longint'($urandom_range(0, 999));
                1:       rv = longint'($urandom_range(0, 999999999));
                default: rv = longint'($urandom & 32'h3FFFFFFF);
            endcase
            convert("rand", rv, int'($urandom_range(31, 60)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
